elevator_call_panel: RTL
========================

ELEVATOR_CALL_PANEL -- requirements
Module: elevator_call_panel

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: cycles a raw button must be stable before its debounced level changes.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles forced between consecutive request pulses.
REQ-003 Parameter DWELL_CYCLES, default 2: consecutive cycles i_floor must equal a floor for that floor to count as served.
REQ-004 i_clk  input  1  sole clock, all state on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_buttons  input  8  raw asynchronous car buttons, bit f = floor f, active-high.
REQ-007 i_floor  input  3  current floor reported by the elevator controller.
REQ-008 o_button_pressed  output  1  one-cycle request strobe to the elevator controller.
REQ-009 o_button_value  output  3  requested floor, valid only while o_button_pressed is high.
REQ-010 o_lamps  output  8  call lamps, bit f high while floor f is pending or issued and not yet served.

Function
REQ-011 Each i_buttons bit SHALL pass a 2-flop synchronizer, then a per-bit debounce counter; debounced level flips only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-012 A debounced rising edge on bit f with o_lamps[f]=0 SHALL set pending[f] the next cycle; holding a button SHALL yield exactly one request; edges with o_lamps[f]=1 are ignored.
REQ-013 FSM states S_IDLE, S_ISSUE, S_GAP; S_IDLE->S_ISSUE when any pending bit set and outstanding<7; S_ISSUE->S_GAP after one cycle; S_GAP->S_IDLE after GAP_CYCLES cycles.
REQ-014 In S_ISSUE: o_button_pressed=1, o_button_value=selected floor, pending[f] cleared, issued[f] set, outstanding incremented; o_button_pressed SHALL be 0 in all other states.
REQ-015 Selection SHALL be round-robin: lowest pending index strictly after the last issued index, wrapping 7->0; after reset the search starts at floor 0.
REQ-016 Outstanding is a 3-bit count of issued-not-served floors; at 7 the FSM SHALL hold in S_IDLE (matches controller queue depth); it never wraps.
REQ-017 A per-cycle match counter SHALL track how long i_floor has been unchanged; when it reaches DWELL_CYCLES, issued[i_floor] and pending[i_floor] SHALL clear and outstanding decrement if issued[i_floor] was set; single-cycle pass-through floors SHALL NOT serve.
REQ-018 o_lamps SHALL equal pending OR issued, registered.
REQ-019 Serve and new debounced edge for the same floor in the same cycle: serve applies, then the edge sets pending[f] (lamp stays lit).
REQ-020 Serve and issue in the same cycle: outstanding net change is zero.

Reset
REQ-021 While i_rst_n=0: o_button_pressed=0, o_button_value=0, o_lamps=0, pending=issued=0, outstanding=0, FSM=S_IDLE, round-robin pointer=7, debounce levels=0, dwell counter=0.
REQ-022 Reset assertion mid-S_ISSUE SHALL drop o_button_pressed asynchronously; all lost requests are discarded, no pulse after release until a new debounced edge.
REQ-023 Buttons held through reset release SHALL register as new edges after debounce.

Configuration
REQ-024 Macro CALL_PANEL_SKIP_CURRENT_EN: when defined, a debounced edge for floor f while i_floor==f and the dwell count has reached DWELL_CYCLES SHALL be dropped (no lamp, no pulse).
REQ-025 Without CALL_PANEL_SKIP_CURRENT_EN, such an edge SHALL be handled as any other request per REQ-012..REQ-014.

Verification
REQ-026 Reset, hold i_buttons=8'h08 for 20 cycles -> o_lamps[3]=1, exactly one pulse with o_button_value=3, issued 2+DEBOUNCE_CYCLES..+4 cycles after press.
REQ-027 Press floors 5,1,6 simultaneously, last issued=4 -> pulses 5,6,1 in that order, each separated by GAP_CYCLES+1 cycles.
REQ-028 1-cycle i_buttons glitch on bit 2 -> no lamp, no pulse.
REQ-029 Issue floor 4, drive i_floor 2,3,4,4 -> lamp 4 stays lit while passing, clears after second cycle at 4, outstanding returns to 0.
REQ-030 Issue 7 floors without serving, press 8th -> lamp lit, no pulse until one floor served, then pulse follows.
REQ-031 i_floor=0 stable, press floor 0 -> with CALL_PANEL_SKIP_CURRENT_EN no lamp/pulse; without it one pulse value 0.

Source files
------------

// File: rtl/elevator_call_panel.sv
// elevator_call_panel: debounced car-button panel issuing round-robin floor requests and tracking service.
// Optional CALL_PANEL_SKIP_CURRENT_EN drops presses for the floor the car is already dwelling at.
module elevator_call_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES = 2,
  parameter int DWELL_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_buttons,
  input  logic [2:0] i_floor,
  output logic       o_button_pressed,
  output logic [2:0] o_button_value,
  output logic [7:0] o_lamps
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = $clog2(DWELL_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
  state_t state_q, state_d;
  logic [7:0] s1_q, s2_q, db_q, db_d, dbp_q, pend_q, pend_d, iss_q, iss_d, lamps_q;
  logic [DW-1:0] cnt_q [8];
  logic [DW-1:0] cnt_d [8];
  logic [2:0] floor_q, ptr_q, sel_q, sel_d, out_q, out_d, cand, pick;
  logic [WW-1:0] dwell_q, dwell_d;
  logic [GW-1:0] gap_q, gap_d;
  logic same, serve, found, issue;
  logic [7:0] rise, accept, serve_m, issue_m, skip_m, avail;
  always_comb begin
    db_d = db_q;
    for (int f = 0; f < 8; f++) begin
      cnt_d[f] = '0;
      if (s2_q[f] != db_q[f]) begin
        if (cnt_q[f] == DW'(DEBOUNCE_CYCLES - 1)) db_d[f] = s2_q[f];
        else cnt_d[f] = cnt_q[f] + 1'b1;
      end
    end
  end
  assign rise = db_q & ~dbp_q;
  assign same = i_floor == floor_q;
  assign dwell_d = !same ? WW'(1) : (dwell_q == WW'(DWELL_CYCLES) ? dwell_q : dwell_q + 1'b1);
  // serve fires once, on the cycle the dwell count first reaches its target
  assign serve = dwell_d == WW'(DWELL_CYCLES) && !(same && dwell_q == WW'(DWELL_CYCLES));
  assign serve_m = serve ? 8'b1 << i_floor : 8'b0;
`ifdef CALL_PANEL_SKIP_CURRENT_EN
  assign skip_m = dwell_d == WW'(DWELL_CYCLES) ? 8'b1 << i_floor : 8'b0;
`else
  assign skip_m = 8'b0;
`endif
  assign accept = rise & ~skip_m & (~lamps_q | serve_m);
  assign avail = pend_q & ~serve_m;
  always_comb begin
    found = 1'b0;
    pick = ptr_q;
    cand = ptr_q;
    for (int k = 1; k <= 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!found && avail[cand]) begin
        found = 1'b1;
        pick = cand;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    sel_d = sel_q;
    issue = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = found && out_q != 3'd7 ? S_ISSUE : S_IDLE;
        sel_d = found ? pick : sel_q;
      end
      S_ISSUE: begin
        issue = 1'b1;
        state_d = S_GAP;
        gap_d = '0;
      end
      S_GAP: begin
        state_d = gap_q == GW'(GAP_CYCLES - 1) ? S_IDLE : S_GAP;
        gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign issue_m = issue ? 8'b1 << sel_q : 8'b0;
  assign pend_d = (pend_q & ~issue_m & ~serve_m) | accept;
  assign iss_d = (iss_q & ~serve_m) | issue_m;
  assign out_d = out_q + {2'b0, issue} - {2'b0, serve & iss_q[i_floor]};
  assign o_button_pressed = state_q == S_ISSUE;
  assign o_button_value = o_button_pressed ? sel_q : 3'd0;
  assign o_lamps = lamps_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      dbp_q <= '0;
      cnt_q <= '{default: '0};
      pend_q <= '0;
      iss_q <= '0;
      lamps_q <= '0;
      state_q <= S_IDLE;
      gap_q <= '0;
      sel_q <= '0;
      ptr_q <= 3'd7;
      out_q <= '0;
      floor_q <= '0;
      dwell_q <= '0;
    end else begin
      s1_q <= i_buttons;
      s2_q <= s1_q;
      db_q <= db_d;
      dbp_q <= db_q;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      iss_q <= iss_d;
      lamps_q <= pend_d | iss_d;
      state_q <= state_d;
      gap_q <= gap_d;
      sel_q <= sel_d;
      ptr_q <= issue ? sel_q : ptr_q;
      out_q <= out_d;
      floor_q <= i_floor;
      dwell_q <= dwell_d;
    end
  end
endmodule
